// File: rtl/channel_hop_controller.sv
// Hop decision FSM: filters the analyzer's channel recommendation, enforces dwell time,
// and runs the req/ack retune handshake with the radio front end.
module channel_hop_controller #(
    parameter int MIN_DWELL   = 16,
    parameter int STABLE_CNT  = 4,
    parameter int ACK_TIMEOUT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rec_channel,
    input  logic       rec_valid,
    input  logic       hop_enable,
    input  logic       hop_ack,
    output logic       hop_req,
    output logic [1:0] hop_channel,
    output logic [1:0] active_channel,
    output logic [7:0] hop_count,
    output logic       hop_fail,
    output logic       busy
);
    localparam int DW = $clog2(MIN_DWELL + 1);
    localparam int SW = $clog2(STABLE_CNT + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [DW-1:0] DWELL_MAX  = DW'(MIN_DWELL);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CNT);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic {MONITOR, REQUEST} state_t;

    state_t        state;
    logic [DW-1:0] dwell_cnt;
    logic [SW-1:0] stable_cnt;
    logic [1:0]    candidate;
    logic [TW-1:0] req_timer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= MONITOR;
            hop_req        <= 1'b0;
            hop_channel    <= '0;
            active_channel <= '0;
            hop_count      <= '0;
            hop_fail       <= 1'b0;
            busy           <= 1'b0;
            dwell_cnt      <= '0;
            stable_cnt     <= '0;
            candidate      <= '0;
            req_timer      <= '0;
        end else begin
            hop_fail <= 1'b0;
            case (state)
                MONITOR: begin
                    if (dwell_cnt != DWELL_MAX)
                        dwell_cnt <= dwell_cnt + 1'b1;

                    // A recommendation must repeat back-to-back to become hop-eligible
                    if (rec_valid) begin
                        if (rec_channel == active_channel)
                            stable_cnt <= '0;
                        else if (rec_channel == candidate) begin
                            if (stable_cnt != STABLE_MAX)
                                stable_cnt <= stable_cnt + 1'b1;
                        end else begin
                            candidate  <= rec_channel;
                            stable_cnt <= SW'(1);
                        end
                    end

                    if (hop_enable && dwell_cnt == DWELL_MAX && stable_cnt == STABLE_MAX) begin
                        state       <= REQUEST;
                        hop_req     <= 1'b1;
                        busy        <= 1'b1;
                        hop_channel <= candidate;
                        req_timer   <= '0;
                    end
                end

                REQUEST: begin
                    // Ack takes priority over a timeout landing on the same edge
                    if (hop_ack) begin
                        active_channel <= hop_channel;
                        if (hop_count != 8'hFF)
                            hop_count <= hop_count + 8'd1;
                        hop_req    <= 1'b0;
                        busy       <= 1'b0;
                        dwell_cnt  <= '0;
                        stable_cnt <= '0;
                        state      <= MONITOR;
                    end else if (req_timer == TIMER_LAST) begin
                        hop_fail   <= 1'b1;
                        hop_req    <= 1'b0;
                        busy       <= 1'b0;
                        dwell_cnt  <= '0;
                        stable_cnt <= '0;
                        state      <= MONITOR;
                    end else begin
                        req_timer <= req_timer + 1'b1;
                    end
                end

                default: state <= MONITOR;
            endcase
        end
    end
endmodule

// File: tb/tb_channel_hop_controller.sv
// Directed bench for channel_hop_controller: table of hop scenarios plus
// hand-written sequences for flicker, timeout spacing, ack hold and reset mid-request.
module tb_channel_hop_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] rec_channel;
    logic       rec_valid;
    logic       hop_enable;
    logic       hop_ack;
    logic       hop_req;
    logic [1:0] hop_channel;
    logic [1:0] active_channel;
    logic [7:0] hop_count;
    logic       hop_fail;
    logic       busy;

    int total = 0;
    int bad   = 0;

    channel_hop_controller #(.MIN_DWELL(16), .STABLE_CNT(4), .ACK_TIMEOUT(32)) dut (
        .clk(clk), .reset(reset), .rec_channel(rec_channel), .rec_valid(rec_valid),
        .hop_enable(hop_enable), .hop_ack(hop_ack), .hop_req(hop_req),
        .hop_channel(hop_channel), .active_channel(active_channel), .hop_count(hop_count),
        .hop_fail(hop_fail), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    ch;        // rec_channel held constant, rec_valid=1
        int    en;        // hop_enable
        int    ack_cyc;   // ack sampled at the end of this req cycle, 0 = never
        int    exp_rise;  // edge after reset release where hop_req rises, 0 = none
        int    exp_len;   // cycles hop_req stays high
        int    exp_hch;
        int    exp_act;
        int    exp_cnt;
        int    exp_fails;
    } scn_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_req"},  int'(hop_req), 0);
        chk({tag, "_hch"},  int'(hop_channel), 0);
        chk({tag, "_act"},  int'(active_channel), 0);
        chk({tag, "_cnt"},  int'(hop_count), 0);
        chk({tag, "_fail"}, int'(hop_fail), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            rec_channel = 2'($urandom_range(0, 3));
            rec_valid   = 1'($urandom_range(0, 1));
            hop_enable  = 1'($urandom_range(0, 1));
            hop_ack     = 1'($urandom_range(0, 1));
            step();
            check_zero($sformatf("rst%0d", i));
        end
        reset   = 1'b0;
        hop_ack = 1'b0;
    endtask

    // Steps until hop_req is high; n = edges taken, or limit+1 on expiry.
    task automatic wait_rise(input int limit, output int n);
        n = limit + 1;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (hop_req) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_scn(input scn_t s);
        int rise, len, fails, hch;
        bit done;
        do_reset();
        rec_valid = 1'b1;
        rec_channel = 2'(s.ch);
        hop_enable = 1'(s.en);
        rise = 0; len = 0; fails = 0; hch = 0; done = 0;
        for (int e = 1; e <= 60 && !done; e++) begin
            step();
            if (hop_fail) fails++;
            if (hop_req) begin
                if (rise == 0) begin
                    rise = e;
                    hch  = int'(hop_channel);
                end
                len++;
            end else if (rise != 0) begin
                done = 1;
            end
            hop_ack = hop_req && s.ack_cyc != 0 && len == s.ack_cyc;
        end
        hop_ack = 1'b0;
        chk({s.name, "_rise"},  rise, s.exp_rise);
        chk({s.name, "_len"},   len, s.exp_len);
        chk({s.name, "_hch"},   hch, s.exp_hch);
        chk({s.name, "_act"},   int'(active_channel), s.exp_act);
        chk({s.name, "_cnt"},   int'(hop_count), s.exp_cnt);
        chk({s.name, "_fails"}, fails, s.exp_fails);
    endtask

    scn_t scns[6];

    initial begin
        int n, reqs;
        reset = 1'b1; rec_channel = '0; rec_valid = 1'b0; hop_enable = 1'b0; hop_ack = 1'b0;

        //         name       ch en ack rise len hch act cnt fails
        scns[0] = '{"basic",   2, 1,  3, 17,  3,  2,  2,  1, 0};
        scns[1] = '{"tmo",     3, 1,  0, 17, 32,  3,  0,  0, 1};
        scns[2] = '{"race",    3, 1, 32, 17, 32,  3,  3,  1, 0};
        scns[3] = '{"gated",   1, 0,  0,  0,  0,  0,  0,  0, 0};
        scns[4] = '{"same",    0, 1,  0,  0,  0,  0,  0,  0, 0};
        scns[5] = '{"ack1",    1, 1,  1, 17,  1,  1,  1,  1, 0};
        foreach (scns[i]) run_scn(scns[i]);

        // Flicker: alternating recommendations never reach persistence
        do_reset();
        rec_valid = 1'b1; hop_enable = 1'b1; reqs = 0;
        for (int i = 0; i < 200; i++) begin
            rec_channel = (i % 2 == 0) ? 2'd1 : 2'd2;
            step();
            if (hop_req) reqs++;
        end
        chk("flicker_reqs", reqs, 0);
        chk("flicker_cnt", int'(hop_count), 0);

        // Timeout: fail pulse is one cycle, next request exactly MIN_DWELL+1 later
        do_reset();
        rec_valid = 1'b1; rec_channel = 2'd3; hop_enable = 1'b1;
        n = 101;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (hop_fail) begin n = i; break; end
        end
        chk("tmo_fail_edge", n, 49);
        chk("tmo_req_low", int'(hop_req), 0);
        step();
        chk("tmo_fail_pulse", int'(hop_fail), 0);
        wait_rise(40, n);
        chk("tmo_respace", n + 1, 17);
        chk("tmo_act", int'(active_channel), 0);
        chk("tmo_cnt", int'(hop_count), 0);

        // Enable dropped mid-request; ack held several cycles counts once
        do_reset();
        rec_valid = 1'b1; rec_channel = 2'd2; hop_enable = 1'b1;
        wait_rise(40, n);
        chk("gate_rise", n, 17);
        hop_enable = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("gate_req_held", int'(hop_req), 1);
        chk("gate_busy", int'(busy), 1);
        hop_ack = 1'b1;
        step();
        chk("hold_req", int'(hop_req), 0);
        chk("hold_act", int'(active_channel), 2);
        chk("hold_cnt", int'(hop_count), 1);
        hop_enable = 1'b1;
        step(); step();
        chk("hold_cnt2", int'(hop_count), 1);
        hop_ack = 1'b0;

        // Reset during the 5th request cycle, then a full dwell is needed again
        rec_channel = 2'd1;
        wait_rise(40, n);
        chk("mid_rise", n, 15);
        for (int i = 0; i < 4; i++) step();
        chk("mid_req_before", int'(hop_req), 1);
        reset = 1'b1;
        step();
        chk("mid_req", int'(hop_req), 0);
        chk("mid_act", int'(active_channel), 0);
        chk("mid_cnt", int'(hop_count), 0);
        chk("mid_busy", int'(busy), 0);
        reset = 1'b0;
        wait_rise(40, n);
        chk("mid_rerise", n, 17);
        chk("mid_hch", int'(hop_channel), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
